hamming_scrub_ctrl: RTL and testbench

HAMMING_SCRUB_CTRL -- requirements
Module: hamming_scrub_ctrl

---
 rtl/hamming_scrub_ctrl.sv | 206 ++++++++++++++++++++
 tb/tb_hamming_scrub_ctrl.sv | 280 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/hamming_scrub_ctrl.sv
// hamming_scrub_ctrl
// Background scrubber for a Hamming-protected memory. One pass reads every
// word from address 0 to DEPTH-1, recomputes parity, writes back words with
// a single correctable error and counts corrected / uncorrectable words.
//
// Ports
//   i_clk, i_rstn             clock, synchronous active-low reset
//   i_start, i_abort          launch a pass / stop at the next word boundary
//   i_interval[15:0]          idle cycles between consecutive words
//   o_busy, o_done            pass in progress / pass-completed pulse
//   o_mem_req, o_mem_we       memory request, 1=write 0=read
//   o_mem_addr[AW-1:0]        word address
//   o_mem_wdata[TW-1:0]       {parity, data} for write-back
//   i_mem_gnt                 request accepted this cycle
//   i_mem_rvalid, i_mem_rdata read return, same layout as wdata
//   o_corr_cnt, o_uncorr_cnt  saturating 16-bit word counts
//
// state   | meaning
// IDLE    | no pass running, counters hold last result
// GAP     | waiting the latched interval before the next word
// RD_REQ  | read request presented until granted
// RD_WAIT | waiting for read data
// CHECK   | syndrome evaluation, correct or count
// WR_REQ  | write-back of corrected word until granted
// NEXT    | word finished: done, abort, or advance address

module hamming_scrub_ctrl #(
  parameter int DW    = 10,
  parameter int PW    = 4,
  parameter int AW    = 8,
  parameter int DEPTH = 256
) (
  input  logic               i_clk,
  input  logic               i_rstn,
  input  logic               i_start,
  input  logic               i_abort,
  input  logic [15:0]        i_interval,
  output logic               o_busy,
  output logic               o_done,
  output logic               o_mem_req,
  output logic               o_mem_we,
  output logic [AW-1:0]      o_mem_addr,
  output logic [DW+PW-1:0]   o_mem_wdata,
  input  logic               i_mem_gnt,
  input  logic               i_mem_rvalid,
  input  logic [DW+PW-1:0]   i_mem_rdata,
  output logic [15:0]        o_corr_cnt,
  output logic [15:0]        o_uncorr_cnt
);

  localparam int TW = DW + PW;
  localparam logic [AW-1:0] LAST_ADDR = AW'(DEPTH - 1);

  typedef enum logic [2:0] {
    IDLE, GAP, RD_REQ, RD_WAIT, CHECK, WR_REQ, NEXT
  } state_t;

  state_t        state, state_nxt;
  logic [AW-1:0] addr;
  logic [TW-1:0] word_q;
  logic [TW-1:0] wdata_q;
  logic [TW-1:0] corrected;
  logic [15:0]   interval_q;
  logic [15:0]   gap_cnt;
  logic [15:0]   corr_cnt;
  logic [15:0]   uncorr_cnt;
  logic          abort_q;
  logic          done_q;
  logic [PW-1:0] syndrome;
  logic          correctable;
  logic          stop_now;

  // Codeword position (1..TW) of data bit k: the k-th position that is not
  // a power of two.
  function automatic int data_pos(input int k);
    int cnt;
    int pos;
    cnt = 0;
    pos = 0;
    for (int p = 1; p <= TW; p++) begin
      if ((p & (p - 1)) != 0) begin
        if (cnt == k) pos = p;
        cnt++;
      end
    end
    return pos;
  endfunction

  always_comb begin
    syndrome = word_q[TW-1:DW];
    for (int k = 0; k < DW; k++) begin
      for (int i = 0; i < PW; i++) begin
        if (((data_pos(k) >> i) & 1) != 0) syndrome[i] = syndrome[i] ^ word_q[k];
      end
    end
    correctable = (syndrome != '0) && (int'(syndrome) <= TW);

    // The syndrome names the codeword position in error; map it back onto
    // either a data bit or a parity bit of the stored layout.
    corrected = word_q;
    for (int k = 0; k < DW; k++) begin
      if (data_pos(k) == int'(syndrome)) corrected[k] = ~word_q[k];
    end
    for (int i = 0; i < PW; i++) begin
      if ((1 << i) == int'(syndrome)) corrected[DW+i] = ~word_q[DW+i];
    end
  end

  // An abort arriving in the NEXT cycle itself is honoured immediately.
  assign stop_now = abort_q | i_abort;

  always_comb begin
    state_nxt = state;
    o_busy    = 1'b1;
    o_mem_req = 1'b0;
    o_mem_we  = 1'b0;
    case (state)
      IDLE: begin
        o_busy = 1'b0;
        if (i_start) state_nxt = RD_REQ;
      end
      GAP: begin
        if (gap_cnt <= 16'd1) state_nxt = RD_REQ;
      end
      RD_REQ: begin
        o_mem_req = 1'b1;
        if (i_mem_gnt) state_nxt = RD_WAIT;
      end
      RD_WAIT: begin
        if (i_mem_rvalid) state_nxt = CHECK;
      end
      CHECK: begin
        state_nxt = correctable ? WR_REQ : NEXT;
      end
      WR_REQ: begin
        o_mem_req = 1'b1;
        o_mem_we  = 1'b1;
        if (i_mem_gnt) state_nxt = NEXT;
      end
      NEXT: begin
        if (addr == LAST_ADDR || stop_now) state_nxt = IDLE;
        else if (interval_q == 16'd0)      state_nxt = RD_REQ;
        else                               state_nxt = GAP;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (!i_rstn) begin
      state      <= IDLE;
      addr       <= '0;
      word_q     <= '0;
      wdata_q    <= '0;
      interval_q <= '0;
      gap_cnt    <= '0;
      corr_cnt   <= '0;
      uncorr_cnt <= '0;
      abort_q    <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state  <= state_nxt;
      done_q <= 1'b0;
      if (state != IDLE && i_abort) abort_q <= 1'b1;
      case (state)
        IDLE: begin
          if (i_start) begin
            addr       <= '0;
            corr_cnt   <= '0;
            uncorr_cnt <= '0;
            interval_q <= i_interval;
          end
        end
        GAP: gap_cnt <= gap_cnt - 16'd1;
        RD_WAIT: begin
          if (i_mem_rvalid) word_q <= i_mem_rdata;
        end
        CHECK: begin
          if (correctable) begin
            wdata_q <= corrected;
            if (corr_cnt != 16'hFFFF) corr_cnt <= corr_cnt + 16'd1;
          end else if (syndrome != '0) begin
            if (uncorr_cnt != 16'hFFFF) uncorr_cnt <= uncorr_cnt + 16'd1;
          end
        end
        NEXT: begin
          if (addr == LAST_ADDR) begin
            done_q <= 1'b1;
          end else if (!stop_now) begin
            addr    <= addr + 1'b1;
            gap_cnt <= interval_q;
          end
        end
        default: ;
      endcase
      if (state != IDLE && state_nxt == IDLE) abort_q <= 1'b0;
    end
  end

  assign o_done       = done_q;
  assign o_mem_addr   = addr;
  assign o_mem_wdata  = wdata_q;
  assign o_corr_cnt   = corr_cnt;
  assign o_uncorr_cnt = uncorr_cnt;

endmodule

// File: tb/tb_hamming_scrub_ctrl.sv
// tb_hamming_scrub_ctrl
// Directed bench for hamming_scrub_ctrl with DEPTH=4, DW=10, PW=4, AW=8.
// A behavioural memory responds to requests with a programmable grant delay
// and read latency and logs what the scrubber did; table-driven passes check
// correction results, hand-written sequences cover gap timing, abort, reset
// mid-transaction and spurious handshakes.

module tb_hamming_scrub_ctrl;

  localparam int AW = 8;
  localparam int TW = 14;

  logic          clk = 1'b0;
  logic          rstn = 1'b0;
  logic          start = 1'b0;
  logic          abort = 1'b0;
  logic [15:0]   interval = 16'd0;
  logic          busy, done, mem_req, mem_we;
  logic [AW-1:0] mem_addr;
  logic [TW-1:0] mem_wdata;
  logic          mem_gnt = 1'b0;
  logic          mem_rvalid = 1'b0;
  logic [TW-1:0] mem_rdata = '0;
  logic [15:0]   corr_cnt, uncorr_cnt;

  always #5 clk = ~clk;

  hamming_scrub_ctrl #(.DW(10), .PW(4), .AW(AW), .DEPTH(4)) dut (
    .i_clk(clk), .i_rstn(rstn), .i_start(start), .i_abort(abort),
    .i_interval(interval), .o_busy(busy), .o_done(done),
    .o_mem_req(mem_req), .o_mem_we(mem_we), .o_mem_addr(mem_addr),
    .o_mem_wdata(mem_wdata), .i_mem_gnt(mem_gnt), .i_mem_rvalid(mem_rvalid),
    .i_mem_rdata(mem_rdata), .o_corr_cnt(corr_cnt), .o_uncorr_cnt(uncorr_cnt)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Controls written only by the main test process.
  logic [TW-1:0] mem [4];
  int            gnt_delay = 0;
  int            rd_lat = 1;
  bit            spur = 1'b0;
  int            clear_tok = 0;

  // State written only by the memory responder.
  int            seen_tok = 0;
  int            cyc = 0;
  int            wait_cnt = 0;
  int            pend_cnt = 0;
  logic [AW-1:0] pend_addr = '0;
  int            n_rd = 0, n_wr = 0, done_cnt = 0;
  logic [AW-1:0] rd_log [16];
  logic [AW-1:0] wr_addr_log = '0;
  logic [TW-1:0] wr_data_log = '0;
  bit            unstable = 1'b0;
  int            last_rd_gnt = -1;
  int            gap_min = 1 << 30, gap_max = -1;
  bit            prev_req = 1'b0, prev_gnt = 1'b0, prev_we = 1'b0;
  logic [AW-1:0] prev_addr = '0;
  logic [TW-1:0] prev_wdata = '0;

  always @(negedge clk) begin
    cyc++;
    if (seen_tok != clear_tok) begin
      seen_tok = clear_tok;
      n_rd = 0; n_wr = 0; done_cnt = 0; unstable = 1'b0;
      last_rd_gnt = -1; gap_min = 1 << 30; gap_max = -1;
      wr_addr_log = '0; wr_data_log = '0;
    end
    mem_rvalid = 1'b0;
    if (pend_cnt > 0) begin
      pend_cnt--;
      if (pend_cnt == 0) begin
        mem_rvalid = 1'b1;
        mem_rdata  = mem[pend_addr[1:0]];
      end
    end
    if (mem_req && prev_req && !prev_gnt &&
        (mem_addr !== prev_addr || mem_we !== prev_we || mem_wdata !== prev_wdata))
      unstable = 1'b1;
    if (mem_req && !prev_req && !mem_we && last_rd_gnt >= 0) begin
      if (cyc - last_rd_gnt < gap_min) gap_min = cyc - last_rd_gnt;
      if (cyc - last_rd_gnt > gap_max) gap_max = cyc - last_rd_gnt;
    end
    mem_gnt = 1'b0;
    if (mem_req) begin
      if (wait_cnt >= gnt_delay) begin
        mem_gnt  = 1'b1;
        wait_cnt = 0;
        if (mem_we) begin
          wr_addr_log = mem_addr;
          wr_data_log = mem_wdata;
          n_wr++;
        end else begin
          if (n_rd < 16) rd_log[n_rd] = mem_addr;
          n_rd++;
          pend_cnt    = rd_lat;
          pend_addr   = mem_addr;
          last_rd_gnt = cyc;
        end
      end else begin
        wait_cnt++;
      end
    end else begin
      wait_cnt = 0;
    end
    if (spur) begin
      mem_gnt    = 1'b1;
      mem_rvalid = 1'b1;
    end
    if (done) done_cnt++;
    prev_req   = mem_req;
    prev_gnt   = mem_gnt;
    prev_addr  = mem_addr;
    prev_we    = mem_we;
    prev_wdata = mem_wdata;
  end

  typedef struct {
    logic [TW-1:0] m [4];
    int            n_wr;
    logic [AW-1:0] wr_addr;
    logic [TW-1:0] wr_data;
    int            corr;
    int            uncorr;
  } vec_t;

  vec_t vecs [6];

  task automatic start_pass(input logic [15:0] iv);
    clear_tok++;
    interval = iv;
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
  endtask

  task automatic wait_idle();
    for (int n = 0; n < 3000 && busy; n++) begin
      @(posedge clk); #1;
    end
    check("pass_ends", 32'(busy), 32'd0);
    repeat (2) @(posedge clk);
    #1;
  endtask

  initial begin
    bit ok;
    bit aborted;

    for (int i = 0; i < 6; i++) begin
      for (int a = 0; a < 4; a++) vecs[i].m[a] = '0;
      vecs[i].n_wr = 0; vecs[i].wr_addr = '0; vecs[i].wr_data = '0;
      vecs[i].corr = 0; vecs[i].uncorr = 0;
    end
    // clean memory
    // data bit 0 flipped at addr 1 -> syndrome 3
    vecs[1].m[1] = 14'h0001; vecs[1].n_wr = 1; vecs[1].wr_addr = 8'd1; vecs[1].corr = 1;
    // parity bit 2 flipped at addr 2 -> syndrome 4
    vecs[2].m[2] = 14'h1000; vecs[2].n_wr = 1; vecs[2].wr_addr = 8'd2; vecs[2].corr = 1;
    // all parity bits set at addr 0 -> syndrome 15, uncorrectable
    vecs[3].m[0] = 14'h3C00; vecs[3].uncorr = 1;
    // data bit 9 (position 14) flipped at addr 3 -> syndrome 14 = TW
    vecs[4].m[3] = 14'h0200; vecs[4].n_wr = 1; vecs[4].wr_addr = 8'd3; vecs[4].corr = 1;
    // valid nonzero codeword at addr 2 plus uncorrectable at addr 0
    vecs[5].m[2] = 14'h0C01; vecs[5].m[0] = 14'h3C00; vecs[5].uncorr = 1;

    for (int a = 0; a < 4; a++) mem[a] = '0;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_req", 32'(mem_req), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_addr", 32'(mem_addr), 32'd0);
    check("rst_wdata", 32'(mem_wdata), 32'd0);
    check("rst_cnts", {corr_cnt, uncorr_cnt}, 32'd0);
    rstn = 1'b1;

    // Table-driven passes
    for (int i = 0; i < 6; i++) begin
      for (int a = 0; a < 4; a++) mem[a] = vecs[i].m[a];
      start_pass(16'd0);
      wait_idle();
      ok = (n_rd == 4);
      for (int k = 0; k < 4; k++) if (rd_log[k] !== 8'(k)) ok = 1'b0;
      check($sformatf("v%0d_reads", i), 32'(ok), 32'd1);
      check($sformatf("v%0d_n_wr", i), 32'(n_wr), 32'(vecs[i].n_wr));
      if (vecs[i].n_wr > 0) begin
        check($sformatf("v%0d_wr_addr", i), 32'(wr_addr_log), 32'(vecs[i].wr_addr));
        check($sformatf("v%0d_wr_data", i), 32'(wr_data_log), 32'(vecs[i].wr_data));
      end
      check($sformatf("v%0d_corr", i), 32'(corr_cnt), 32'(vecs[i].corr));
      check($sformatf("v%0d_uncorr", i), 32'(uncorr_cnt), 32'(vecs[i].uncorr));
      check($sformatf("v%0d_done", i), 32'(done_cnt), 32'd1);
    end

    // Interval 3 with grant delayed 2 cycles: grant -> RD_WAIT -> CHECK ->
    // NEXT -> 3 x GAP -> RD_REQ gives 7 cycles from read grant to next request.
    for (int a = 0; a < 4; a++) mem[a] = '0;
    gnt_delay = 2;
    start_pass(16'd3);
    interval = 16'd0;
    wait_idle();
    check("gap_reads", 32'(n_rd), 32'd4);
    check("gap_min", 32'(gap_min), 32'd7);
    check("gap_max", 32'(gap_max), 32'd7);
    check("gap_req_stable", 32'(unstable), 32'd0);
    check("gap_done", 32'(done_cnt), 32'd1);

    // Abort while write-back of addr 1 is pending
    mem[1] = 14'h0001;
    aborted = 1'b0;
    start_pass(16'd0);
    for (int n = 0; n < 3000 && busy; n++) begin
      @(posedge clk); #1;
      if (!aborted && mem_req && mem_we) begin
        abort = 1'b1;
        aborted = 1'b1;
        @(posedge clk); #1 abort = 1'b0;
      end
    end
    wait_idle();
    check("abort_n_wr", 32'(n_wr), 32'd1);
    check("abort_wr_addr", 32'(wr_addr_log), 32'd1);
    check("abort_wr_stable", 32'(unstable), 32'd0);
    check("abort_n_rd", 32'(n_rd), 32'd2);
    check("abort_no_done", 32'(done_cnt), 32'd0);
    check("abort_corr", 32'(corr_cnt), 32'd1);

    // Reset while waiting for read data of addr 1; addr 0 left a corrected
    // word (0x0C01) and corr_cnt=1 behind, and the late rvalid must be ignored.
    mem[1] = '0;
    mem[0] = 14'h0C00;
    gnt_delay = 0;
    rd_lat = 3;
    start_pass(16'd0);
    for (int n = 0; n < 100 && n_rd < 2; n++) begin
      @(posedge clk); #1;
    end
    check("rst_mid_reached", 32'(n_rd), 32'd2);
    check("rst_mid_pre_wdata", 32'(mem_wdata), 32'h0C01);
    rstn = 1'b0;
    @(posedge clk); #1;
    check("rst_mid_req", 32'(mem_req), 32'd0);
    check("rst_mid_busy", 32'(busy), 32'd0);
    check("rst_mid_we_done", {30'd0, mem_we, done}, 32'd0);
    check("rst_mid_addr", 32'(mem_addr), 32'd0);
    check("rst_mid_wdata", 32'(mem_wdata), 32'd0);
    check("rst_mid_cnts", {corr_cnt, uncorr_cnt}, 32'd0);
    rstn = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    check("late_rvalid_busy", 32'(busy), 32'd0);
    check("late_rvalid_req", 32'(mem_req), 32'd0);
    rd_lat = 1;

    // Spurious grant/rvalid in IDLE must not start anything
    spur = 1'b1;
    repeat (3) @(posedge clk);
    #1 spur = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("spur_busy", 32'(busy), 32'd0);
    check("spur_req", 32'(mem_req), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
